// File: rtl/axi_line_arbiter_if.sv
// AXI4 master-side bundle (AR/R/AW/W/B) shared by the line arbiter and its slave.
// IDs are 4 bits, data is one 32-bit word per beat.
interface axi_line_arbiter_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        output awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        input  awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_line_arbiter.sv
// Round-robin AXI4 master for NPORT cache clients: write-back, then fill,
// or single-word uncached accesses, one transaction outstanding at a time.
module axi_line_arbiter #(
    parameter int NPORT      = 3,
    parameter int LINE_WORDS = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NPORT-1:0]           port_rreq,
    input  logic [NPORT*32-1:0]        port_raddr,
    input  logic [NPORT-1:0]           port_rsingle,
    input  logic [NPORT-1:0]           port_wreq,
    input  logic [NPORT*32-1:0]        port_waddr,
    input  logic [NPORT-1:0]           port_wsingle,
    input  logic [NPORT*4-1:0]         port_wstrb,
    input  logic [NPORT*LINE_WORDS*32-1:0] port_wdata,
    output logic [LINE_WORDS*32-1:0]   port_rdata,
    output logic [NPORT-1:0]           port_done,
    output logic [NPORT-1:0]           port_err,
    output logic                       busy,
    axi_line_arbiter_if.master         axi
);

    localparam int W = LINE_WORDS * 32;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [3:0]  LINE_LEN  = 4'(LINE_WORDS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  rr_q, rr_d;
    logic        rreq_q, rreq_d;
    logic        rsingle_q, rsingle_d;
    logic        wsingle_q, wsingle_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] waddr_q, waddr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [3:0]  beat_q, beat_d;
    logic [W-1:0] rdata_q, rdata_d;

    logic [7:0]  pend8;
    logic [7:0]  wreq8;
    logic        pend_any;
    logic [2:0]  pick;
    logic [3:0]  sum;
    logic [3:0]  rr_nxt;
    logic [31:0] wword;
    logic [3:0]  wlast_beat;
    logic        unused_ids;

    assign pend8 = 8'(port_rreq | port_wreq);
    assign wreq8 = 8'(port_wreq);
    assign unused_ids = ^{axi.bid, axi.rid};

    // Lowest rotation distance from rr_q wins; scanning downward lets it overwrite.
    always_comb begin
        pend_any = 1'b0;
        pick     = 3'd0;
        sum      = 4'd0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            sum = {1'b0, rr_q} + 4'(k);
            if (sum >= 4'(NPORT)) sum = sum - 4'(NPORT);
            if (pend8[sum[2:0]]) begin
                pend_any = 1'b1;
                pick     = sum[2:0];
            end
        end
    end

    always_comb begin
        wword = 32'd0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (beat_q == 4'(i)) wword = wdata_q[32*i +: 32];
        end
    end

    assign wlast_beat = wsingle_q ? 4'd0 : LINE_LEN;

    always_comb begin
        rr_nxt = {1'b0, gnt_q} + 4'd1;
        if (rr_nxt >= 4'(NPORT)) rr_nxt = 4'd0;
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        rreq_d    = rreq_q;
        rsingle_d = rsingle_q;
        wsingle_d = wsingle_q;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        beat_d    = beat_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pend_any) begin
                    gnt_d  = pick;
                    err_d  = 1'b0;
                    beat_d = 4'd0;
                    for (int i = 0; i < NPORT; i++) begin
                        if (pick == 3'(i)) begin
                            rreq_d    = port_rreq[i];
                            rsingle_d = port_rsingle[i];
                            wsingle_d = port_wsingle[i];
                            raddr_d   = port_raddr[32*i +: 32];
                            waddr_d   = port_waddr[32*i +: 32];
                            wstrb_d   = port_wstrb[4*i +: 4];
                            wdata_d   = port_wdata[W*i +: W];
                        end
                    end
                    state_d = wreq8[pick] ? S_AW : S_AR;
                end
            end
            S_AW: begin
                if (axi.awready) state_d = S_W;
            end
            S_W: begin
                if (axi.wready) begin
                    if (beat_q == wlast_beat) begin
                        beat_d  = 4'd0;
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            S_B: begin
                if (axi.bvalid) begin
                    if (axi.bresp != 2'b00) err_d = 1'b1;
                    state_d = rreq_q ? S_AR : S_DONE;
                end
            end
            S_AR: begin
                if (axi.arready) begin
                    beat_d  = 4'd0;
                    state_d = S_R;
                end
            end
            S_R: begin
                if (axi.rvalid) begin
                    for (int i = 0; i < LINE_WORDS; i++) begin
                        if (beat_q == 4'(i)) rdata_d[32*i +: 32] = axi.rdata;
                    end
                    if (axi.rresp != 2'b00) err_d = 1'b1;
                    beat_d = beat_q + 4'd1;
                    if (axi.rlast) state_d = S_DONE;
                end
            end
            S_DONE: begin
                rr_d    = rr_nxt[2:0];
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            gnt_q     <= 3'd0;
            rr_q      <= 3'd0;
            rreq_q    <= 1'b0;
            rsingle_q <= 1'b0;
            wsingle_q <= 1'b0;
            raddr_q   <= 32'd0;
            waddr_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            beat_q    <= 4'd0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            rreq_q    <= rreq_d;
            rsingle_q <= rsingle_d;
            wsingle_q <= wsingle_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
            rdata_q   <= rdata_d;
        end
    end

    // Payload outputs are gated by their valid so reset and idle read as zero.
    assign axi.awvalid = (state_q == S_AW);
    assign axi.awid    = {1'b0, gnt_q};
    assign axi.awaddr  = !axi.awvalid ? 32'd0 :
                         wsingle_q ? waddr_q : (waddr_q & LINE_MASK);
    assign axi.awlen   = (axi.awvalid && !wsingle_q) ? LINE_LEN : 4'd0;
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;

    assign axi.wvalid  = (state_q == S_W);
    assign axi.wdata   = axi.wvalid ? wword : 32'd0;
    assign axi.wstrb   = !axi.wvalid ? 4'd0 :
                         wsingle_q ? wstrb_q : 4'hF;
    assign axi.wlast   = axi.wvalid && (beat_q == wlast_beat);

    assign axi.bready  = (state_q == S_B);

    assign axi.arvalid = (state_q == S_AR);
    assign axi.arid    = {1'b0, gnt_q};
    assign axi.araddr  = !axi.arvalid ? 32'd0 :
                         rsingle_q ? raddr_q : (raddr_q & LINE_MASK);
    assign axi.arlen   = (axi.arvalid && !rsingle_q) ? LINE_LEN : 4'd0;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;

    assign axi.rready  = (state_q == S_R);

    always_comb begin
        port_done = '0;
        port_err  = '0;
        for (int i = 0; i < NPORT; i++) begin
            port_done[i] = (state_q == S_DONE) && (gnt_q == 3'(i));
            port_err[i]  = (state_q == S_DONE) && (gnt_q == 3'(i)) && err_q;
        end
    end

    assign port_rdata = rdata_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_line_arbiter.sv
// Scoreboard bench: stimulus queues expected AXI/done events, a negedge
// slave+monitor pops and compares them as the DUT produces them.
module tb_axi_line_arbiter;
    localparam int NP = 3;
    localparam int LW = 8;
    localparam int W  = LW * 32;

    localparam int K_AW   = 0;
    localparam int K_W    = 1;
    localparam int K_B    = 2;
    localparam int K_AR   = 3;
    localparam int K_DONE = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [NP-1:0]      port_rreq, port_rsingle, port_wreq, port_wsingle;
    logic [NP*32-1:0]   port_raddr, port_waddr;
    logic [NP*4-1:0]    port_wstrb;
    logic [NP*W-1:0]    port_wdata;
    logic [W-1:0]       port_rdata;
    logic [NP-1:0]      port_done, port_err;
    logic               busy;

    axi_line_arbiter_if axi ();

    axi_line_arbiter #(.NPORT(NP), .LINE_WORDS(LW)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .port_rreq    (port_rreq),
        .port_raddr   (port_raddr),
        .port_rsingle (port_rsingle),
        .port_wreq    (port_wreq),
        .port_waddr   (port_waddr),
        .port_wsingle (port_wsingle),
        .port_wstrb   (port_wstrb),
        .port_wdata   (port_wdata),
        .port_rdata   (port_rdata),
        .port_done    (port_done),
        .port_err     (port_err),
        .busy         (busy),
        .axi          (axi)
    );

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [W-1:0] d;
    } ev_t;

    ev_t   sb[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    string kn[5] = '{"AW", "W", "B", "AR", "DONE"};

    logic [31:0] rbase = 32'h100;
    int          err_beat = -1;
    bit          wtoggle = 1'b0;
    bit          b_pend = 1'b0;
    bit          r_act = 1'b0;
    int          r_beat = 0;
    int          r_len = 0;
    int          cur_beat = -1;
    logic [3:0]  r_id = 4'd0;
    int          last_end = 0;
    int          ar_cyc = 0;
    int          done_cyc = 0;
    logic [W-1:0] exp_rd = '0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(int kind, logic [31:0] a, logic [31:0] b, logic [W-1:0] d);
        ev_t e;
        e.kind = kind;
        e.a = a;
        e.b = b;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic observe(int kind, logic [31:0] a, logic [31:0] b, logic [W-1:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected %s event: a=%h b=%h", kn[kind], a, b);
        end else begin
            e = sb.pop_front();
            chki({kn[e.kind], " kind"}, kind, e.kind);
            if (kind == e.kind && kind != K_B) begin
                chk({kn[kind], " a"}, W'(a), W'(e.a));
                chk({kn[kind], " b"}, W'(b), W'(e.b));
                if (kind == K_DONE) chk("DONE rdata", d, e.d);
            end
        end
    endtask

    // AXI slave and monitor: drive ready/valid at negedge, then log handshakes
    // that the coming posedge will complete.
    initial begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.bid = 0; axi.arready = 0; axi.rvalid = 0; axi.rdata = 0;
        axi.rresp = 0; axi.rlast = 0; axi.rid = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0;
                b_pend = 0; r_act = 0; cur_beat = -1;
                continue;
            end
            axi.awready = axi.awvalid;
            axi.arready = axi.arvalid;
            axi.wready  = wtoggle ? ~axi.wready : 1'b1;
            axi.bvalid  = b_pend;
            axi.bresp   = 2'b00;
            if (r_act) begin
                axi.rvalid = 1'b1;
                axi.rdata  = rbase + ({28'd0, r_id} << 8) + 32'(r_beat);
                axi.rlast  = (r_beat == r_len);
                axi.rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
                axi.rid    = r_id;
                cur_beat   = r_beat;
            end else begin
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
                axi.rresp  = 2'b00;
                cur_beat   = -1;
            end
            #1;
            if (axi.awvalid && axi.awready)
                observe(K_AW, axi.awaddr, 32'({axi.awid, axi.awlen}), '0);
            if (axi.wvalid && axi.wready) begin
                observe(K_W, axi.wdata, 32'({axi.wlast, axi.wstrb}), '0);
                if (axi.wlast) b_pend = 1'b1;
            end
            if (axi.bvalid && axi.bready) begin
                observe(K_B, 32'd0, 32'd0, '0);
                b_pend = 1'b0;
                last_end = cyc;
            end
            if (axi.arvalid && axi.arready) begin
                observe(K_AR, axi.araddr, 32'({axi.arid, axi.arlen}), '0);
                r_act = 1'b1;
                r_beat = 0;
                r_len = int'(axi.arlen);
                r_id = axi.arid;
                ar_cyc = cyc;
            end
            if (axi.rvalid && axi.rready) begin
                if (axi.rlast) begin
                    r_act = 1'b0;
                    last_end = cyc;
                end else begin
                    r_beat++;
                end
            end
            if (port_done != '0) begin
                observe(K_DONE, 32'(port_done), 32'(port_err), port_rdata);
                chki("done_latency", cyc, last_end + 1);
                done_cyc = cyc;
            end
        end
    end

    task automatic set_req(int p, bit r, logic [31:0] ra, bit rs, bit w,
                           logic [31:0] wa, bit ws, logic [3:0] st,
                           logic [W-1:0] wd);
        port_rreq[p] = r;
        port_raddr[32*p +: 32] = ra;
        port_rsingle[p] = rs;
        port_wreq[p] = w;
        port_waddr[32*p +: 32] = wa;
        port_wsingle[p] = ws;
        port_wstrb[4*p +: 4] = st;
        port_wdata[W*p +: W] = wd;
    endtask

    task automatic wait_dones(int n, bit keep);
        int got = 0;
        for (int t = 0; t < 3000 && got < n; t++) begin
            @(negedge aclk);
            #2;
            if (port_done != '0) begin
                got++;
                if (!keep) begin
                    port_rreq = port_rreq & ~port_done;
                    port_wreq = port_wreq & ~port_done;
                end else if (got == n) begin
                    port_rreq = '0;
                    port_wreq = '0;
                end
            end
        end
        chki("done_count", got, n);
        port_rreq = '0;
        port_wreq = '0;
    endtask

    task automatic exp_read(int p, logic [31:0] a, bit single);
        int nw = single ? 1 : LW;
        push(K_AR, single ? a : (a & 32'hFFFF_FFE0),
             32'({4'(p), single ? 4'd0 : 4'd7}), '0);
        for (int k = 0; k < nw; k++)
            exp_rd[32*k +: 32] = rbase + (32'(p) << 8) + 32'(k);
    endtask

    task automatic exp_done(int p, bit err);
        push(K_DONE, 32'(1) << p, err ? (32'(1) << p) : 32'd0, exp_rd);
    endtask

    logic [W-1:0] wd;
    int req_cyc;
    int seq[5] = '{0, 1, 2, 0, 1};
    logic [31:0] rr_addr[3] = '{32'h1000_0004, 32'h2000_0008, 32'h3000_000C};
    bit hit;

    initial begin
        port_rreq = '0; port_rsingle = '0; port_wreq = '0; port_wsingle = '0;
        port_raddr = '0; port_waddr = '0; port_wstrb = '0; port_wdata = '0;
        repeat (3) @(negedge aclk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(port_done), '0);
        chk("rst_err", W'(port_err), '0);
        chk("rst_rdata", port_rdata, '0);
        chk("rst_valids", W'({axi.awvalid, axi.wvalid, axi.arvalid}), '0);
        chk("rst_readies", W'({axi.bready, axi.rready}), '0);
        chk("rst_addr", W'({axi.awaddr, axi.araddr, axi.arlen}), '0);
        aresetn = 1'b1;
        @(negedge aclk);

        // line fill on port 0
        exp_read(0, 32'h1FC0_0024, 1'b0);
        exp_done(0, 1'b0);
        req_cyc = cyc;
        set_req(0, 1, 32'h1FC0_0024, 0, 0, 32'd0, 0, 4'h0, '0);
        wait_dones(1, 1'b0);
        chki("ar_rise", ar_cyc, req_cyc + 1);
        chki("fill_latency", done_cyc - ar_cyc, LW + 1);

        // eviction then fill on port 1, wready toggling
        wtoggle = 1'b1;
        for (int k = 0; k < LW; k++) wd[32*k +: 32] = 32'hA0 + 32'(k);
        push(K_AW, 32'h0000_1040, 32'h17, '0);
        for (int k = 0; k < LW; k++)
            push(K_W, 32'hA0 + 32'(k), (k == LW - 1) ? 32'h1F : 32'h0F, '0);
        push(K_B, 32'd0, 32'd0, '0);
        exp_read(1, 32'h0000_2040, 1'b0);
        exp_done(1, 1'b0);
        set_req(1, 1, 32'h0000_2040, 0, 1, 32'h0000_1040, 0, 4'h0, wd);
        wait_dones(1, 1'b0);
        wtoggle = 1'b0;

        // uncached write on port 2
        wd = '0;
        wd[31:0] = 32'hDEAD_BEEF;
        push(K_AW, 32'hBFAF_8002, 32'h20, '0);
        push(K_W, 32'hDEAD_BEEF, 32'h1C, '0);
        push(K_B, 32'd0, 32'd0, '0);
        exp_done(2, 1'b0);
        set_req(2, 0, 32'd0, 0, 1, 32'hBFAF_8002, 1, 4'b1100, wd);
        wait_dones(1, 1'b0);

        // round-robin with all ports requesting
        for (int i = 0; i < 5; i++) begin
            exp_read(seq[i], rr_addr[seq[i]], 1'b1);
            exp_done(seq[i], 1'b0);
        end
        for (int p = 0; p < NP; p++)
            set_req(p, 1, rr_addr[p], 1, 0, 32'd0, 0, 4'h0, '0);
        wait_dones(5, 1'b1);

        // read error on beat 3, then a clean transaction
        err_beat = 3;
        exp_read(0, 32'h0000_3010, 1'b0);
        exp_done(0, 1'b1);
        set_req(0, 1, 32'h0000_3010, 0, 0, 32'd0, 0, 4'h0, '0);
        wait_dones(1, 1'b0);
        err_beat = -1;
        exp_read(0, 32'h4000_0000, 1'b1);
        exp_done(0, 1'b0);
        set_req(0, 1, 32'h4000_0000, 1, 0, 32'd0, 0, 4'h0, '0);
        wait_dones(1, 1'b0);

        // reset in the middle of a fill on port 2
        exp_read(2, 32'h5000_0000, 1'b0);
        set_req(2, 1, 32'h5000_0000, 0, 0, 32'd0, 0, 4'h0, '0);
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge aclk);
            #2;
            if (axi.rvalid && cur_beat == 4) hit = 1'b1;
        end
        chki("reach_beat4", int'(hit), 1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_rready", W'(axi.rready), '0);
        chk("mid_rst_busy", W'(busy), '0);
        chk("mid_rst_rdata", port_rdata, '0);
        port_rreq = '0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        exp_rd = '0;
        exp_read(0, 32'h6000_0010, 1'b1);
        exp_done(0, 1'b0);
        exp_read(1, 32'h7000_0020, 1'b1);
        exp_done(1, 1'b0);
        set_req(0, 1, 32'h6000_0010, 1, 0, 32'd0, 0, 4'h0, '0);
        set_req(1, 1, 32'h7000_0020, 1, 0, 32'd0, 0, 4'h0, '0);
        wait_dones(2, 1'b0);

        repeat (3) @(negedge aclk);
        chki("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
